noise_table_loader: RTL and testbench

- Producer side of the noise-CDF load interface.
- Reads 128 64-bit cumulative-probability thresholds from an on-chip table memory.
- Streams them one entry per cycle on load_mem/location/mem_data into the noise generator.
- Waits for the generator's done_wait acknowledge, then reports load status.
- Checks that the table is monotonic non-decreasing, so a corrupt CDF is flagged before noise injection starts.

---
 rtl/noise_pkg.sv | 13 +
 rtl/noise_table_loader_if.sv | 24 ++
 rtl/rd_lat_pipe.sv | 32 +++
 rtl/noise_table_loader.sv | 118 +++++++++++
 tb/tb_noise_table_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// Constants and loader state encoding shared by the CDF loader, noise generator and top-level control.
package noise_pkg;
   localparam int CDF_ENTRIES = 128;
   localparam int CDF_W       = 64;

   typedef enum logic [2:0] {
      LD_IDLE     = 3'd0,
      LD_FETCH    = 3'd1,
      LD_DRAIN    = 3'd2,
      LD_WAIT_ACK = 3'd3,
      LD_DONE     = 3'd4
   } loader_state_e;
endpackage

// File: rtl/noise_table_loader_if.sv
// Table-memory read port plus the load_mem/location/mem_data stream into the noise generator.
interface noise_table_loader_if
   import noise_pkg::*;
#(
   parameter int MEM_AW = 10
) ();
   logic              mem_rd_en;
   logic [MEM_AW-1:0] mem_rd_addr;
   logic [CDF_W-1:0]  mem_rd_data;
   logic              load_mem;
   logic [7:0]        location;
   logic [CDF_W-1:0]  mem_data;
   logic              done_wait;

   modport master (
      output mem_rd_en, mem_rd_addr, load_mem, location, mem_data,
      input  mem_rd_data, done_wait
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr, load_mem, location, mem_data,
      output mem_rd_data, done_wait
   );
endinterface

// File: rtl/rd_lat_pipe.sv
// Valid/index delay line matching the table memory read latency; out_* lines up with the returned data.
module rd_lat_pipe #(
   parameter int DEPTH = 2,
   parameter int IW    = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_vld,
   input  logic [IW-1:0] in_idx,
   output logic          out_vld,
   output logic [IW-1:0] out_idx
);
   logic [DEPTH-1:0] vld_sr;
   logic [IW-1:0]    idx_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_sr <= '0;
         for (int i = 0; i < DEPTH; i++) idx_sr[i] <= '0;
      end else begin
         vld_sr[0] <= in_vld;
         idx_sr[0] <= in_idx;
         for (int i = 1; i < DEPTH; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            idx_sr[i] <= idx_sr[i-1];
         end
      end
   end

   assign out_vld = vld_sr[DEPTH-1];
   assign out_idx = idx_sr[DEPTH-1];
endmodule

// File: rtl/noise_table_loader.sv
// Streams the CDF table into the noise generator one entry per cycle and flags non-monotonic entries.
// Start to WAIT_ACK entry is 1+ENTRIES+RD_LATENCY cycles; the stream has no backpressure, only the final done_wait ack.
module noise_table_loader
   import noise_pkg::*;
#(
   parameter int ENTRIES     = CDF_ENTRIES,
   parameter int MEM_AW      = 10,
   parameter int BASE_ADDR   = 0,
   parameter int RD_LATENCY  = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   noise_table_loader_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err_nonmono,
   output logic [7:0]           err_index,
   output logic                 err_timeout
);
   localparam int ACK_CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [2:0] S_IDLE     = LD_IDLE;
   localparam logic [2:0] S_FETCH    = LD_FETCH;
   localparam logic [2:0] S_DRAIN    = LD_DRAIN;
   localparam logic [2:0] S_WAIT_ACK = LD_WAIT_ACK;
   localparam logic [2:0] S_DONE     = LD_DONE;

   logic [2:0]        state;
   logic [7:0]        rd_idx;
   logic [7:0]        issue_idx;
   logic [ACK_CW-1:0] ack_cnt;
   logic              ret_vld;
   logic [7:0]        ret_idx;
   logic              ret_ok;

   rd_lat_pipe #(
      .DEPTH (RD_LATENCY),
      .IW    (8)
   ) u_rd_lat_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .in_vld  (bus.mem_rd_en),
      .in_idx  (issue_idx),
      .out_vld (ret_vld),
      .out_idx (ret_idx)
   );

   assign ret_ok = ret_vld && ((state == S_FETCH) || (state == S_DRAIN));
   assign busy   = (state == S_FETCH) || (state == S_DRAIN) || (state == S_WAIT_ACK);
   assign done   = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= S_IDLE;
         rd_idx          <= '0;
         issue_idx       <= '0;
         ack_cnt         <= '0;
         bus.mem_rd_en   <= 1'b0;
         bus.mem_rd_addr <= '0;
         bus.load_mem    <= 1'b0;
         bus.location    <= '0;
         bus.mem_data    <= '0;
         err_nonmono     <= 1'b0;
         err_index       <= '0;
         err_timeout     <= 1'b0;
      end else begin
         bus.mem_rd_en <= 1'b0;
         bus.load_mem  <= 1'b0;

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_FETCH;
                  rd_idx      <= '0;
                  err_nonmono <= 1'b0;
                  err_index   <= '0;
                  err_timeout <= 1'b0;
               end
            end
            S_FETCH: begin
               bus.mem_rd_en   <= 1'b1;
               bus.mem_rd_addr <= MEM_AW'(BASE_ADDR + int'(rd_idx));
               issue_idx       <= rd_idx;
               rd_idx          <= rd_idx + 8'd1;
               if (rd_idx == 8'(ENTRIES - 1)) state <= S_DRAIN;
            end
            S_WAIT_ACK: begin
               if (bus.done_wait) begin
                  state <= S_DONE;
               end else if (ack_cnt == ACK_CW'(ACK_TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            default: ;
         endcase

         // Returns arrive in issue order, so bus.mem_data still holds the predecessor entry here.
         if (ret_ok) begin
            bus.load_mem <= 1'b1;
            bus.location <= ret_idx;
            bus.mem_data <= bus.mem_rd_data;
            if ((ret_idx != 8'd0) && (bus.mem_rd_data < bus.mem_data) && !err_nonmono) begin
               err_nonmono <= 1'b1;
               err_index   <= ret_idx;
            end
            if (ret_idx == 8'(ENTRIES - 1)) begin
               state   <= S_WAIT_ACK;
               ack_cnt <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_noise_table_loader.sv
// Two loaders (read latency 2 and 4) driven in lockstep and checked every cycle against a timeline model.
module tb_noise_table_loader;
   import noise_pkg::*;

   localparam int N   = 128;
   localparam int TMO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn  = 1'b0;
   logic       start = 1'b0;
   logic [1:0] dw    = '0;

   logic [63:0] tbl [N];
   logic [9:0]  pa  [2][4];

   noise_table_loader_if #(.MEM_AW(10)) ifa ();
   noise_table_loader_if #(.MEM_AW(10)) ifb ();

   logic [1:0] o_en, o_ld, o_busy, o_done, o_nm, o_to;
   logic [9:0]  o_addr [2];
   logic [7:0]  o_loc  [2];
   logic [63:0] o_dat  [2];
   logic [7:0]  o_idx  [2];

   noise_table_loader #(.RD_LATENCY(2)) dut_a (
      .clk(clk), .rstn(rstn), .start(start), .bus(ifa),
      .busy(o_busy[0]), .done(o_done[0]), .err_nonmono(o_nm[0]),
      .err_index(o_idx[0]), .err_timeout(o_to[0]));

   noise_table_loader #(.RD_LATENCY(4)) dut_b (
      .clk(clk), .rstn(rstn), .start(start), .bus(ifb),
      .busy(o_busy[1]), .done(o_done[1]), .err_nonmono(o_nm[1]),
      .err_index(o_idx[1]), .err_timeout(o_to[1]));

   assign o_en[0] = ifa.mem_rd_en;   assign o_en[1] = ifb.mem_rd_en;
   assign o_ld[0] = ifa.load_mem;    assign o_ld[1] = ifb.load_mem;
   assign o_addr[0] = ifa.mem_rd_addr; assign o_addr[1] = ifb.mem_rd_addr;
   assign o_loc[0] = ifa.location;   assign o_loc[1] = ifb.location;
   assign o_dat[0] = ifa.mem_data;   assign o_dat[1] = ifb.mem_data;
   assign ifa.done_wait = dw[0];
   assign ifb.done_wait = dw[1];

   // Table memory: the address is captured at each edge and read out RD_LATENCY edges later.
   always_ff @(posedge clk) begin
      pa[0][0] <= ifa.mem_rd_addr;
      pa[1][0] <= ifb.mem_rd_addr;
      for (int j = 1; j < 4; j++) begin
         pa[0][j] <= pa[0][j-1];
         pa[1][j] <= pa[1][j-1];
      end
   end
   assign ifa.mem_rd_data = tbl[pa[0][1][6:0]];
   assign ifb.mem_rd_data = tbl[pa[1][3][6:0]];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;
   int ack_mode  = 3;
   int lat [2] = '{2, 4};

   int          m_t [2], m_wk [2];
   logic        m_wait [2], m_done [2], m_en [2], m_ld [2], m_nm [2], m_to [2];
   logic [9:0]  m_addr [2];
   logic [7:0]  m_loc [2], m_idx [2];
   logic [63:0] m_dat [2];

   int   first_en [2], first_ld [2], beats [2], runs [2], last_ld [2], done_rise [2], to_rise [2];
   logic prev_ld [2], prev_done [2], prev_to [2];

   task automatic chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
      end
   endtask

   task automatic set_ramp();
      for (int k = 0; k < N; k++) tbl[k] = (k >= 256) ? '1 : (64'(k) << 56);
   endtask

   task automatic set_nonmono();
      set_ramp();
      tbl[40] = tbl[39] - 64'd1;
      tbl[90] = tbl[89] - 64'd5;
   endtask

   // Timeline model: reads issue on cycles 1..N after the start edge, entry k is presented
   // on cycle k+lat+2, the ack window opens on the last entry.
   task automatic model_edge(int i, logic s_rstn, logic s_start, logic s_dw);
      int k;
      if (!s_rstn) begin
         m_t[i] = -1; m_wk[i] = 0; m_wait[i] = 0; m_done[i] = 0; m_en[i] = 0; m_ld[i] = 0;
         m_addr[i] = '0; m_loc[i] = '0; m_dat[i] = '0; m_nm[i] = 0; m_idx[i] = '0; m_to[i] = 0;
         return;
      end
      m_en[i] = 0;
      m_ld[i] = 0;
      if (m_wait[i]) begin
         m_wk[i]++;
         if (s_dw) begin
            m_wait[i] = 0; m_done[i] = 1;
         end else if (m_wk[i] == TMO) begin
            m_to[i] = 1; m_wait[i] = 0; m_done[i] = 1;
         end
      end else if (m_t[i] >= 0) begin
         m_t[i]++;
         if (m_t[i] >= 1 && m_t[i] <= N) begin
            m_en[i] = 1;
            m_addr[i] = 10'(m_t[i] - 1);
         end
         k = m_t[i] - lat[i] - 2;
         if (k >= 0 && k < N) begin
            m_ld[i] = 1;
            if (k > 0 && tbl[k] < tbl[k-1] && !m_nm[i]) begin
               m_nm[i] = 1; m_idx[i] = 8'(k);
            end
            m_loc[i] = 8'(k);
            m_dat[i] = tbl[k];
            if (k == N - 1) begin
               m_wait[i] = 1; m_wk[i] = 0; m_t[i] = -1;
            end
         end
      end else if (s_start) begin
         m_t[i] = 0; m_done[i] = 0; m_nm[i] = 0; m_idx[i] = '0; m_to[i] = 0;
      end
   endtask

   task automatic observe(int i);
      if (o_en[i] && first_en[i] < 0) first_en[i] = cyc;
      if (o_ld[i]) begin
         if (!prev_ld[i]) runs[i]++;
         beats[i]++;
         if (first_ld[i] < 0) first_ld[i] = cyc;
         last_ld[i] = cyc;
      end
      if (o_done[i] && !prev_done[i] && done_rise[i] < 0) done_rise[i] = cyc;
      if (o_to[i] && !prev_to[i]) to_rise[i] = cyc;
      prev_ld[i] = o_ld[i]; prev_done[i] = o_done[i]; prev_to[i] = o_to[i];
   endtask

   task automatic compare(int i);
      chk("mem_rd_en",   i, o_en[i],   m_en[i]);
      chk("mem_rd_addr", i, o_addr[i], m_addr[i]);
      chk("load_mem",    i, o_ld[i],   m_ld[i]);
      chk("location",    i, o_loc[i],  m_loc[i]);
      chk("mem_data",    i, o_dat[i],  m_dat[i]);
      chk("busy",        i, o_busy[i], m_t[i] >= 0 || m_wait[i]);
      chk("done",        i, o_done[i], m_done[i]);
      chk("err_nonmono", i, o_nm[i],   m_nm[i]);
      chk("err_index",   i, o_idx[i],  m_idx[i]);
      chk("err_timeout", i, o_to[i],   m_to[i]);
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 2; i++) begin
         first_en[i] = -1; first_ld[i] = -1; beats[i] = 0; runs[i] = 0;
         last_ld[i] = -1; done_rise[i] = -1; to_rise[i] = -1;
      end
   endtask

   task automatic tick();
      logic s_r, s_s;
      logic [1:0] s_d;
      s_r = rstn; s_s = start; s_d = dw;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         model_edge(i, s_r, s_s, s_d[i]);
         observe(i);
         compare(i);
      end
      for (int i = 0; i < 2; i++)
         dw[i] = (ack_mode == 0) || (ack_mode > 0 && m_wait[i] && (m_wk[i] + 1 >= ack_mode));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic run_until_done(string nm);
      int n = 0;
      while (o_done != 2'b11 && n < 600) begin
         tick();
         n++;
      end
      chk(nm, 0, o_done, 2'b11);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin prev_ld[i] = 0; prev_done[i] = 0; prev_to[i] = 0; end
      clear_obs();
      set_ramp();
      rstn = 1'b0;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      rstn = 1'b1;
      tick();
      chk("rst_busy", 0, o_busy, 2'b00);
      chk("rst_done", 0, o_done, 2'b00);
      chk("rst_load", 0, o_ld, 2'b00);
      chk("rst_errs", 0, {o_nm, o_to, o_idx[0], o_idx[1]}, 0);

      // Monotonic ramp, ack 3 cycles after the last entry.
      ack_mode = 3;
      clear_obs();
      pulse_start();
      run_until_done("ramp_done");
      chk("ramp_first_beat", 0, first_ld[0] - first_en[0], 3);
      chk("ramp_first_beat", 1, first_ld[1] - first_en[1], 5);
      chk("ramp_beats", 0, beats[0], 128);
      chk("ramp_beats", 1, beats[1], 128);
      chk("ramp_runs", 0, runs[0], 1);
      chk("ramp_wait_entry", 0, last_ld[0] - start_cyc, 131);
      chk("ramp_wait_entry", 1, last_ld[1] - start_cyc, 133);
      chk("ramp_ack", 0, done_rise[0] - last_ld[0], 3);
      chk("ramp_errs", 0, {o_nm, o_to}, 0);

      // Two decreasing entries; only the first is reported.
      set_nonmono();
      clear_obs();
      pulse_start();
      run_until_done("nonmono_done");
      chk("nonmono_flag", 0, o_nm, 2'b11);
      chk("nonmono_index", 0, o_idx[0], 40);
      chk("nonmono_index", 1, o_idx[1], 40);
      chk("nonmono_beats", 0, beats[0], 128);
      chk("nonmono_beats", 1, beats[1], 128);

      // Acknowledge never comes.
      set_ramp();
      ack_mode = -1;
      clear_obs();
      pulse_start();
      chk("restart_clears", 0, {o_nm, o_idx[0]}, 0);
      run_until_done("timeout_done");
      chk("timeout_gap", 0, to_rise[0] - last_ld[0], 16);
      chk("timeout_gap", 1, to_rise[1] - last_ld[1], 16);
      chk("timeout_flag", 0, o_to, 2'b11);

      // Reset while location 60 is presented.
      ack_mode = 3;
      clear_obs();
      pulse_start();
      begin
         int n = 0;
         while (!(o_ld[0] && o_loc[0] == 8'd60) && n < 300) begin tick(); n++; end
         chk("reach_loc60", 0, n < 300, 1);
      end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("midrst_load", 0, o_ld, 2'b00);
      chk("midrst_busy", 0, o_busy, 2'b00);
      clear_obs();
      repeat (20) tick();
      chk("midrst_stale", 0, beats[0] + beats[1], 0);
      pulse_start();
      run_until_done("reload_done");
      chk("reload_beats", 0, beats[0], 128);

      // Start pulses while busy are ignored.
      clear_obs();
      pulse_start();
      repeat (9) tick();
      start = 1'b1; tick(); start = 1'b0;
      repeat (118) tick();
      start = 1'b1; tick(); start = 1'b0;
      run_until_done("ignored_done");
      chk("ignored_beats", 0, beats[0], 128);
      chk("ignored_runs", 1, runs[1], 1);
      chk("ignored_wait_entry", 0, last_ld[0] - start_cyc, 131);

      // Ack already high on entry, then a restart from DONE clears the error.
      set_nonmono();
      ack_mode = 0;
      clear_obs();
      pulse_start();
      run_until_done("early_ack_done");
      chk("early_ack", 0, done_rise[0] - last_ld[0], 1);
      chk("early_nonmono", 0, o_nm, 2'b11);
      set_ramp();
      clear_obs();
      pulse_start();
      chk("restart_nm_clear", 0, o_nm, 2'b00);
      run_until_done("restart_done");
      chk("restart_first_beat", 1, first_ld[1] - first_en[1], 5);
      chk("restart_first_beat", 0, first_ld[0] - first_en[0], 3);
      chk("restart_errs", 0, {o_nm, o_to}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
